// File: rtl/io_pkg.sv
// Shared constants and port decode for the Lynx I/O port block.
package io_pkg;

   localparam logic [7:0] IO_BANK   = 8'h7F;
   localparam logic [7:0] IO_VCTL   = 8'h80;
   localparam logic [7:0] IO_DAC    = 8'h84;
   localparam logic [7:0] IO_CRTC_A = 8'h86;
   localparam logic [7:0] IO_CRTC_D = 8'h87;

   localparam logic [7:0] BANK_RST   = 8'h00;
   localparam logic [7:0] VCTL_RST   = 8'h00;
   localparam logic [5:0] DAC_RST    = 6'h20;
   localparam logic [7:0] RD_DEFAULT = 8'hFF;

   typedef enum logic [2:0] {
      P_NONE,
      P_BANK,
      P_VCTL,
      P_DAC,
      P_CRTC
   } port_e;

   // Both CRTC ports map to P_CRTC; a[0] picks address vs data.
   function automatic port_e decode(input logic [7:0] adr);
      port_e p;
      p = P_NONE;
      case (adr)
         IO_BANK:   p = P_BANK;
         IO_VCTL:   p = P_VCTL;
         IO_DAC:    p = P_DAC;
         IO_CRTC_A: p = P_CRTC;
         IO_CRTC_D: p = P_CRTC;
         default:   p = P_NONE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/io_strobe.sv
// ne-qualified bus sampler: one write-event pulse per I/O write cycle,
// plus a read-active level.
module io_strobe
   import io_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic ne,
   input  logic iorq,
   input  logic rd,
   input  logic wr,
   output logic wr_evt,
   output logic rd_act
);

   logic prev_iorq_q, prev_rd_q, prev_wr_q;
   logic wr_now, wr_prev;
   logic unused_prev_rd;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_iorq_q <= 1'b1;
         prev_rd_q   <= 1'b1;
         prev_wr_q   <= 1'b1;
      end else if (ne) begin
         prev_iorq_q <= iorq;
         prev_rd_q   <= rd;
         prev_wr_q   <= wr;
      end
   end

   assign wr_now  = ~iorq & ~wr;
   assign wr_prev = ~prev_iorq_q & ~prev_wr_q;
   assign wr_evt  = ne & wr_now & ~wr_prev;
   assign rd_act  = ne & ~iorq & ~rd;

   // Reads are level-qualified, so the sampled rd is kept but not needed.
   assign unused_prev_rd = prev_rd_q;

endmodule

// File: rtl/io_ports.sv
// Lynx I/O ports: bank/vctl/dac/CRTC writes and keyboard/CRTC read mux.
// Define IO_CRTC_READ_EN to return crtc_d on reads of port 0x87.
module io_ports
   import io_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ne,
   input  logic        iorq,
   input  logic        rd,
   input  logic        wr,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   output logic [7:0]  q,
   output logic [7:0]  bank,
   output logic [7:0]  vctl,
   output logic [5:0]  dac,
   output logic [3:0]  krow,
   input  logic [7:0]  kcol,
   output logic        crtc_rs,
   output logic        crtc_we,
   output logic [7:0]  crtc_dq,
   input  logic [7:0]  crtc_d
);

   logic       wr_evt, rd_act;
   port_e      sel;
   logic [7:0] rdata;
   logic       unused_in;

   logic [7:0] bank_q, bank_d, vctl_q, vctl_d;
   logic [5:0] dac_q, dac_d;
   logic [7:0] q_q, q_d, crtc_dq_q, crtc_dq_d;
   logic       crtc_rs_q, crtc_rs_d, crtc_we_q, crtc_we_d;

   io_strobe u_strobe (
      .clock  (clock),
      .reset  (reset),
      .ne     (ne),
      .iorq   (iorq),
      .rd     (rd),
      .wr     (wr),
      .wr_evt (wr_evt),
      .rd_act (rd_act)
   );

   assign sel = decode(a[7:0]);

   always_comb begin
      rdata = RD_DEFAULT;
      case (sel)
         P_VCTL: rdata = kcol;
`ifdef IO_CRTC_READ_EN
         P_CRTC: if (a[0]) rdata = crtc_d;
`endif
         default: rdata = RD_DEFAULT;
      endcase
   end

   always_comb begin
      bank_d    = bank_q;
      vctl_d    = vctl_q;
      dac_d     = dac_q;
      crtc_dq_d = crtc_dq_q;
      crtc_rs_d = crtc_rs_q;
      crtc_we_d = 1'b0;
      q_d       = rd_act ? rdata : q_q;
      if (wr_evt) begin
         case (sel)
            P_BANK: bank_d = d;
            P_VCTL: vctl_d = d;
            P_DAC:  dac_d  = d[5:0];
            P_CRTC: begin
               crtc_dq_d = d;
               crtc_rs_d = a[0];
               crtc_we_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bank_q    <= BANK_RST;
         vctl_q    <= VCTL_RST;
         dac_q     <= DAC_RST;
         q_q       <= RD_DEFAULT;
         crtc_dq_q <= 8'h00;
         crtc_rs_q <= 1'b0;
         crtc_we_q <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         vctl_q    <= vctl_d;
         dac_q     <= dac_d;
         q_q       <= q_d;
         crtc_dq_q <= crtc_dq_d;
         crtc_rs_q <= crtc_rs_d;
         crtc_we_q <= crtc_we_d;
      end
   end

   assign krow    = a[11:8];
   assign q       = q_q;
   assign bank    = bank_q;
   assign vctl    = vctl_q;
   assign dac     = dac_q;
   assign crtc_dq = crtc_dq_q;
   assign crtc_rs = crtc_rs_q;
   assign crtc_we = crtc_we_q;

`ifdef IO_CRTC_READ_EN
   assign unused_in = ^a[15:12];
`else
   assign unused_in = ^{a[15:12], crtc_d};
`endif

endmodule
